// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, ALU operation codes, operand selects and the ID/EX payload.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SLT    = 4'd7,
    ALU_SLTU   = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_PASS_B = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_U, IMM_SHAMT
  } imm_type_e;

  typedef enum logic [1:0] { A_ZERO, A_RS1, A_PC } a_sel_e;
  typedef enum logic [1:0] { B_ZERO, B_RS2, B_IMM, B_FOUR } b_sel_e;

  typedef struct packed {
    alu_op_e   op;
    a_sel_e    a_sel;
    b_sel_e    b_sel;
    imm_type_e imm;
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    logic      jump;
    logic      illegal;
  } dec_ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    alu_op_e     op;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } idex_t;

  // alt only matters for funct3 000 (SUB) and 101 (SRA); callers gate it for I-type.
  function automatic alu_op_e funct3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7[5] into ALU code, operand selects and control flags.
module alu_op_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output dec_ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o       = '0;
    ctrl_o.op    = ALU_ADD;
    ctrl_o.a_sel = A_ZERO;
    ctrl_o.b_sel = B_ZERO;
    ctrl_o.imm   = IMM_NONE;
    case (opcode_i)
      OPC_OP: begin
        ctrl_o.op        = funct3_to_op(funct3_i, funct7b5_i);
        ctrl_o.a_sel     = A_RS1;
        ctrl_o.b_sel     = B_RS2;
        ctrl_o.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        // bit 30 is part of the immediate for ADDI; only SRAI/SRLI treat it as an op selector
        ctrl_o.op        = funct3_to_op(funct3_i, funct7b5_i && (funct3_i == 3'b101));
        ctrl_o.a_sel     = A_RS1;
        ctrl_o.b_sel     = B_IMM;
        ctrl_o.imm       = (funct3_i[1:0] == 2'b01) ? IMM_SHAMT : IMM_I;
        ctrl_o.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_o.a_sel     = A_RS1;
        ctrl_o.b_sel     = B_IMM;
        ctrl_o.imm       = IMM_I;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.a_sel     = A_RS1;
        ctrl_o.b_sel     = B_IMM;
        ctrl_o.imm       = IMM_S;
        ctrl_o.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.op     = ALU_SUB;
        ctrl_o.a_sel  = A_RS1;
        ctrl_o.b_sel  = B_RS2;
        ctrl_o.branch = 1'b1;
      end
      OPC_LUI: begin
        ctrl_o.op        = ALU_PASS_B;
        ctrl_o.b_sel     = B_IMM;
        ctrl_o.imm       = IMM_U;
        ctrl_o.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_o.a_sel     = A_PC;
        ctrl_o.b_sel     = B_IMM;
        ctrl_o.imm       = IMM_U;
        ctrl_o.reg_write = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        ctrl_o.a_sel     = A_PC;
        ctrl_o.b_sel     = B_FOUR;
        ctrl_o.jump      = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode stage: immediate generation, operand muxing and the ID/EX register feeding the ALU.
module alu_decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_operand_a,
  output logic [31:0] ex_operand_b,
  output logic [3:0]  ex_alu_controller,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [2:0]  ex_funct3,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_illegal
);

  dec_ctrl_t   ctrl;
  logic [31:0] imm, op_a, op_b;
  idex_t       idex_d, idex_q;

  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  alu_op_decode u_dec (
    .opcode_i   (if_instr[6:0]),
    .funct3_i   (if_instr[14:12]),
    .funct7b5_i (if_instr[30]),
    .ctrl_o     (ctrl)
  );

  always_comb begin
    case (ctrl.imm)
      IMM_I:     imm = {{20{if_instr[31]}}, if_instr[31:20]};
      IMM_S:     imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      IMM_U:     imm = {if_instr[31:12], 12'b0};
      IMM_SHAMT: imm = {27'b0, if_instr[24:20]};
      default:   imm = '0;
    endcase
  end

  always_comb begin
    case (ctrl.a_sel)
      A_RS1:   op_a = rs1_data;
      A_PC:    op_a = if_pc;
      default: op_a = '0;
    endcase
    case (ctrl.b_sel)
      B_RS2:   op_b = rs2_data;
      B_IMM:   op_b = imm;
      B_FOUR:  op_b = 32'd4;
      default: op_b = '0;
    endcase
  end

  // flush beats stall: a squashed slot must not be held into EX
  always_comb begin
    idex_d = idex_q;
    if (flush) begin
      idex_d = '0;
    end else if (!stall) begin
      if (!if_valid) begin
        idex_d = '0;
      end else begin
        idex_d.valid      = 1'b1;
        idex_d.pc         = if_pc;
        idex_d.operand_a  = op_a;
        idex_d.operand_b  = op_b;
        idex_d.op         = ctrl.op;
        idex_d.store_data = rs2_data;
        idex_d.rd         = if_instr[11:7];
        idex_d.rs1        = if_instr[19:15];
        idex_d.rs2        = if_instr[24:20];
        idex_d.funct3     = if_instr[14:12];
        idex_d.reg_write  = ctrl.reg_write && (if_instr[11:7] != 5'd0);
        idex_d.mem_read   = ctrl.mem_read;
        idex_d.mem_write  = ctrl.mem_write;
        idex_d.branch     = ctrl.branch;
        idex_d.jump       = ctrl.jump;
        idex_d.illegal    = ctrl.illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign ex_valid          = idex_q.valid;
  assign ex_pc             = idex_q.pc;
  assign ex_operand_a      = idex_q.operand_a;
  assign ex_operand_b      = idex_q.operand_b;
  assign ex_alu_controller = idex_q.op;
  assign ex_store_data     = idex_q.store_data;
  assign ex_rd             = idex_q.rd;
  assign ex_rs1            = idex_q.rs1;
  assign ex_rs2            = idex_q.rs2;
  assign ex_funct3         = idex_q.funct3;
  assign ex_reg_write      = idex_q.reg_write;
  assign ex_mem_read       = idex_q.mem_read;
  assign ex_mem_write      = idex_q.mem_write;
  assign ex_branch         = idex_q.branch;
  assign ex_jump           = idex_q.jump;
  assign ex_illegal        = idex_q.illegal;

endmodule
